z_scan_gen: RTL

Z_SCAN_GEN -- requirements
Module: z_scan_gen

---
 rtl/z_scan_gen.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/z_scan_gen.sv
// rtl/z_scan_gen.sv - block scan-order address generator (raster, Morton/Z, zigzag)
// Optional macro Z_SCAN_XY_EN adds registered zx/zy coordinate outputs.
module z_scan_gen #(
   parameter int LOG2_DIM = 3,
   parameter int ZW       = 2*LOG2_DIM
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          sob,
   input  logic [1:0]    mode,
   input  logic          zid_rdy,
   output logic [ZW-1:0] zid,
   output logic          zid_vld,
   output logic          eob,
   output logic          busy
`ifdef Z_SCAN_XY_EN
   ,
   output logic [LOG2_DIM-1:0] zx,
   output logic [LOG2_DIM-1:0] zy
`endif
);

   localparam int L = LOG2_DIM;
   localparam logic [ZW-1:0] LAST = '1;
   localparam logic [L-1:0]  EDGE = '1;

   typedef enum logic {IDLE, SCAN} state_t;

   state_t        state, state_d;
   logic [1:0]    mode_q, mode_d;
   logic [ZW-1:0] k, k_d, k_inc;
   logic [ZW-1:0] zid_d, morton_nxt, zig_nxt;
   logic          dir_up, dir_d, zig_dir_nxt;
   logic          vld_d, eob_d, busy_d;
   logic          accept, last;
   logic [L-1:0]  cur_x, cur_y, nx, ny;

   assign accept = zid_vld & zid_rdy;
   assign last   = (k == LAST);
   assign k_inc  = k + ZW'(1);
   assign cur_x  = zid[L-1:0];
   assign cur_y  = zid[ZW-1:L];

   // Morton: de-interleave the element index, bit 0 goes to x
   always_comb begin
      morton_nxt = '0;
      for (int i = 0; i < L; i++) begin
         morton_nxt[i]   = k_inc[2*i];
         morton_nxt[L+i] = k_inc[2*i+1];
      end
   end

   // Zigzag walks from the current {y,x}; edge tests come before the diagonal step
   always_comb begin
      nx          = cur_x;
      ny          = cur_y;
      zig_dir_nxt = dir_up;
      if (dir_up) begin
         if (cur_x == EDGE) begin
            ny          = cur_y + L'(1);
            zig_dir_nxt = 1'b0;
         end else if (cur_y == '0) begin
            nx          = cur_x + L'(1);
            zig_dir_nxt = 1'b0;
         end else begin
            nx = cur_x + L'(1);
            ny = cur_y - L'(1);
         end
      end else begin
         if (cur_y == EDGE) begin
            nx          = cur_x + L'(1);
            zig_dir_nxt = 1'b1;
         end else if (cur_x == '0) begin
            ny          = cur_y + L'(1);
            zig_dir_nxt = 1'b1;
         end else begin
            nx = cur_x - L'(1);
            ny = cur_y + L'(1);
         end
      end
      zig_nxt = {ny, nx};
   end

   always_comb begin
      state_d = state;
      mode_d  = mode_q;
      k_d     = k;
      zid_d   = zid;
      dir_d   = dir_up;
      vld_d   = zid_vld;
      eob_d   = eob;
      busy_d  = busy;
      if (sob) begin
         // sob always wins: starts a block from IDLE, aborts or chains from SCAN
         state_d = SCAN;
         mode_d  = mode;
         k_d     = '0;
         zid_d   = '0;
         dir_d   = 1'b1;
         vld_d   = 1'b1;
         eob_d   = 1'b0;
         busy_d  = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               vld_d  = 1'b0;
               eob_d  = 1'b0;
               busy_d = 1'b0;
            end
            SCAN: begin
               if (accept) begin
                  if (last) begin
                     state_d = IDLE;
                     vld_d   = 1'b0;
                     eob_d   = 1'b0;
                     busy_d  = 1'b0;
                  end else begin
                     k_d   = k_inc;
                     eob_d = (k_inc == LAST);
                     case (mode_q)
                        2'd1: zid_d = morton_nxt;
                        2'd2: begin
                           zid_d = zig_nxt;
                           dir_d = zig_dir_nxt;
                        end
                        default: zid_d = k_inc;
                     endcase
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         mode_q  <= 2'd0;
         k       <= '0;
         zid     <= '0;
         dir_up  <= 1'b1;
         zid_vld <= 1'b0;
         eob     <= 1'b0;
         busy    <= 1'b0;
      end else begin
         state   <= state_d;
         mode_q  <= mode_d;
         k       <= k_d;
         zid     <= zid_d;
         dir_up  <= dir_d;
         zid_vld <= vld_d;
         eob     <= eob_d;
         busy    <= busy_d;
      end
   end

`ifdef Z_SCAN_XY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zx <= '0;
         zy <= '0;
      end else begin
         zx <= zid_d[L-1:0];
         zy <= zid_d[ZW-1:L];
      end
   end
`endif

endmodule
